project_led_blink: RTL and testbench

PROJECT_LED_BLINK -- requirements
Module: project_led_blink

---
 rtl/project_led_blink.sv | 88 ++++++++
 tb/tb_project_led_blink.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/project_led_blink.sv
// Avalon-MM LED register block with a per-bit blink mask.
// A prescaler toggles a phase bit that gates LEDs whose MODE bit is set.
module project_led_blink #(
   parameter int                WIDTH      = 8,
   parameter int                CNT_W      = 24,
   parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mode_q, mode_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic             wr_en;
   logic [31:0]      rd;
   logic             unused_wd;

   assign wr_en     = chipselect & ~write_n;
   assign unused_wd = ^writedata;

   always_comb begin
      data_d   = data_q;
      mode_d   = mode_q;
      period_d = period_q;
      if (cnt_q == period_q) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         phase_d = phase_q;
      end
      if (wr_en) begin
         case (address)
            3'd0: data_d = writedata[WIDTH-1:0];
            3'd1: mode_d = writedata[WIDTH-1:0];
            3'd2: begin
               // restarting the prescaler avoids a wrap when PERIOD shrinks
               period_d = writedata[CNT_W-1:0];
               cnt_d    = '0;
               phase_d  = 1'b0;
            end
            3'd4: data_d = data_q | writedata[WIDTH-1:0];
            3'd5: data_d = data_q & ~writedata[WIDTH-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q   <= RESET_DATA;
         mode_q   <= '0;
         period_q <= '1;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
      end else begin
         data_q   <= data_d;
         mode_q   <= mode_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
      end
   end

   always_comb begin
      rd = '0;
      case (address)
         3'd0: rd[WIDTH-1:0] = data_q;
         3'd1: rd[WIDTH-1:0] = mode_q;
         3'd2: rd[CNT_W-1:0] = period_q;
         3'd3: rd[0]         = phase_q;
         default: ;
      endcase
   end

   assign readdata = rd;
   assign out_port = data_q & (~mode_q | {WIDTH{phase_q}});

endmodule

// File: tb/tb_project_led_blink.sv
// Randomized self-checking bench for project_led_blink.
// Reference model tracks elapsed cycles since the last prescaler restart.
module tb_project_led_blink;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int checks = 0;
   int errors = 0;

   logic [7:0]  m_data;
   logic [7:0]  m_mode;
   logic [23:0] m_period;
   longint      m_t;

   project_led_blink dut (
      .clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(readdata),
      .out_port(out_port)
   );

   always #5 clk = ~clk;

   function automatic logic m_phase();
      longint pp;
      pp = longint'(m_period) + 1;
      return ((m_t / pp) % 2) == 1;
   endfunction

   function automatic logic [7:0] m_out();
      return m_data & (~m_mode | {8{m_phase()}});
   endfunction

   function automatic logic [31:0] m_read(logic [2:0] a);
      case (a)
         3'd0: return {24'b0, m_data};
         3'd1: return {24'b0, m_mode};
         3'd2: return {8'b0, m_period};
         3'd3: return {31'b0, m_phase()};
         default: return 32'b0;
      endcase
   endfunction

   task automatic tick();
      logic        r, w;
      logic [2:0]  a;
      logic [31:0] d;
      r = reset_n;
      w = chipselect & ~write_n;
      a = address;
      d = writedata;
      @(posedge clk);
      if (!r) begin
         m_data = 8'h00; m_mode = 8'h00;
         m_period = 24'hFFFFFF; m_t = 0;
      end else begin
         m_t = m_t + 1;
         if (w) begin
            case (a)
               3'd0: m_data = d[7:0];
               3'd1: m_mode = d[7:0];
               3'd2: begin m_period = d[23:0]; m_t = 0; end
               3'd4: m_data = m_data | d[7:0];
               3'd5: m_data = m_data & ~d[7:0];
               default: ;
            endcase
         end
      end
      #1;
   endtask

   task automatic wr(logic [2:0] a, logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] exp_r [4];
      exp_r[0] = 32'h0; exp_r[1] = 32'h0;
      exp_r[2] = 32'h00FFFFFF; exp_r[3] = 32'h0;
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      address = 3'd0; writedata = 32'h0;
      tick(); tick();
      reset_n = 1'b1;
      checks++;
      if (out_port !== 8'h00) begin
         errors++;
         $display("FAIL reset_out got %h exp 00", out_port);
      end
      for (int i = 0; i < 4; i++) begin
         address = 3'(i); #1;
         checks++;
         if (readdata !== exp_r[i]) begin
            errors++;
            $display("FAIL reset_rd%0d got %h exp %h", i, readdata, exp_r[i]);
         end
      end
   endtask

   task automatic test_data_write();
      wr(3'd0, 32'hFFFF_FFA5);
      address = 3'd0; #1;
      checks++;
      if (out_port !== 8'hA5) begin
         errors++;
         $display("FAIL data_out got %h exp a5", out_port);
      end
      checks++;
      if (readdata !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL data_rd got %h exp 000000a5", readdata);
      end
   endtask

   task automatic test_set_clear();
      wr(3'd0, 32'hF0);
      wr(3'd4, 32'h0F);
      address = 3'd0; #1;
      checks++;
      if (readdata !== 32'hFF) begin
         errors++;
         $display("FAIL outset got %h exp ff", readdata);
      end
      wr(3'd5, 32'h81);
      address = 3'd0; #1;
      checks++;
      if (readdata !== 32'h7E) begin
         errors++;
         $display("FAIL outclear got %h exp 7e", readdata);
      end
      for (int a = 4; a < 8; a++) begin
         address = 3'(a); #1;
         checks++;
         if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL wo_rd%0d got %h exp 0", a, readdata);
         end
      end
   endtask

   task automatic test_blink_p3();
      int n, run;
      logic b;
      wr(3'd2, 32'd3);
      wr(3'd1, 32'h01);
      wr(3'd0, 32'h01);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (out_port !== m_out() || out_port[7:1] !== 7'h0) begin
            errors++;
            $display("FAIL p3_out%0d got %h exp %h", i, out_port, m_out());
         end
         tick();
      end
      b = out_port[0]; n = 0;
      while (out_port[0] == b && n < 20) begin tick(); n++; end
      b = out_port[0]; run = 0;
      while (out_port[0] == b && run < 20) begin tick(); run++; end
      checks++;
      if (run != 4) begin
         errors++;
         $display("FAIL p3_halfperiod got %0d exp 4", run);
      end
   endtask

   task automatic test_blink_p0();
      logic [7:0] prev;
      wr(3'd2, 32'd0);
      wr(3'd1, 32'hFF);
      wr(3'd0, 32'hFF);
      address = 3'd3;
      prev = out_port;
      for (int i = 0; i < 8; i++) begin
         tick();
         #1;
         checks++;
         if (out_port !== ~prev || (out_port !== 8'h00 && out_port !== 8'hFF)
             || readdata[0] !== out_port[0] || out_port !== m_out()) begin
            errors++;
            $display("FAIL p0_alt%0d got %h st %h exp %h",
                     i, out_port, readdata, ~prev);
         end
         prev = out_port;
      end
   endtask

   task automatic test_period_terminal();
      int n;
      logic ph;
      wr(3'd1, 32'h00);
      wr(3'd2, 32'd2);
      tick(); tick();
      address = 3'd3; #1;
      ph = readdata[0];
      wr(3'd2, 32'd5);
      address = 3'd3; #1;
      checks++;
      if (readdata[0] !== 1'b0 || m_phase() !== 1'b0 || ph !== 1'b0) begin
         errors++;
         $display("FAIL term_phase got %b exp 0", readdata[0]);
      end
      n = 0;
      while (readdata[0] == 1'b0 && n < 20) begin
         tick(); #1; n++;
      end
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL term_next got %0d exp 6", n);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_r [4];
      exp_r[0] = 32'h0; exp_r[1] = 32'h0;
      exp_r[2] = 32'h00FFFFFF; exp_r[3] = 32'h0;
      wr(3'd2, 32'd1);
      wr(3'd1, 32'hFF);
      wr(3'd0, 32'hFF);
      tick(); tick(); tick();
      reset_n = 1'b0;
      wr(3'd0, 32'h3C);
      reset_n = 1'b1;
      checks++;
      if (out_port !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_out got %h exp 00", out_port);
      end
      for (int i = 0; i < 4; i++) begin
         address = 3'(i); #1;
         checks++;
         if (readdata !== exp_r[i]) begin
            errors++;
            $display("FAIL rstmid_rd%0d got %h exp %h", i, readdata, exp_r[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset_n    = ($urandom_range(0, 60) != 0);
         chipselect = $urandom_range(0, 2) == 0;
         write_n    = $urandom_range(0, 1) == 0;
         address    = 3'($urandom_range(0, 7));
         writedata  = $urandom;
         if (address == 3'd2 && $urandom_range(0, 9) != 0)
            writedata = 32'($urandom_range(0, 7)) | (writedata & 32'hFF00_0000);
         #1;
         checks++;
         if (out_port !== m_out() || readdata !== m_read(address)) begin
            errors++;
            $display("FAIL rand%0d out %h/%h rd@%0d %h/%h", i, out_port,
                     m_out(), address, readdata, m_read(address));
         end
         tick();
      end
      reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      m_data = 8'h00; m_mode = 8'h00; m_period = 24'hFFFFFF; m_t = 0;
      #2;
      test_reset();
      test_data_write();
      test_set_clear();
      test_blink_p3();
      test_blink_p0();
      test_period_terminal();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
